// File: rtl/uart_packet_loader_if.sv
// Byte-in / buffer-write-out bundle of the UART packet loader.
interface uart_packet_loader_if #(
   parameter int unsigned ADDR_W = 10
);
   // Byte stream from the UART receiver
   logic [7:0]        rx_data;
   logic              rx_done;

   // Buffer write port
   logic              wr_en;
   logic              wr_sel;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   // Packet status
   logic              busy;
   logic              pkt_done;
   logic              pkt_err;
   logic [1:0]        err_code;

   // Byte source side (UART receiver / host model)
   modport master (
      output rx_data, rx_done,
      input  wr_en, wr_sel, wr_addr, wr_data, busy, pkt_done, pkt_err, err_code
   );

   // Loader side
   modport slave (
      input  rx_data, rx_done,
      output wr_en, wr_sel, wr_addr, wr_data, busy, pkt_done, pkt_err, err_code
   );
endinterface

// File: rtl/uart_packet_loader.sv
// Frames UART bytes into sync/cmd/len/payload/xor-checksum packets and streams
// each payload byte into the weight or input buffer write port.
module uart_packet_loader #(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned TIMEOUT_CLKS = 20000,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input logic                clk,
   input logic                reset_n,
   uart_packet_loader_if.slave bus
);

   localparam int unsigned CNT_W   = ADDR_W + 1;
   localparam int unsigned LEN_W   = 16;
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CLKS) + 1;
   localparam int unsigned MAX_LEN = 32'd1 << ADDR_W;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_LEN     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CMD     = 3'd1,
      S_LEN_LO  = 3'd2,
      S_LEN_HI  = 3'd3,
      S_PAYLOAD = 3'd4,
      S_CHECK   = 3'd5
   } state_e;

   state_e state_q, state_d;

   // Datapath registers
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [LEN_W-1:0]  len_q,      len_d;
   logic [7:0]        csum_q,     csum_d;
   logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;

   // Registered outputs
   logic              wr_en_q,    wr_en_d;
   logic              wr_sel_q,   wr_sel_d;
   logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
   logic [7:0]        wr_data_q,  wr_data_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;
   logic              err_q,      err_d;
   logic [1:0]        err_code_q, err_code_d;

   // Decodes of the incoming byte against the packet context
   logic [LEN_W-1:0]  len_full;
   logic              len_ovf;
   logic              len_zero;
   logic              last_byte;
   logic              timeout_hit;
   logic              is_sync;

   assign len_full    = {bus.rx_data, len_q[7:0]};
   assign len_ovf     = (32'(len_full) > MAX_LEN);
   assign len_zero    = (len_full == '0);
   assign last_byte   = ((32'(cnt_q) + 32'd1) == 32'(len_q));
   // A byte arriving on the expiry cycle takes priority over the timeout
   assign timeout_hit = (state_q != S_IDLE) && !bus.rx_done &&
                        (idle_cnt_q == TO_W'(TIMEOUT_CLKS - 1));
   assign is_sync     = (bus.rx_data == SYNC_BYTE);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: advance only on a received byte, or abort on timeout
   always_comb begin
      state_d = state_q;
      if (timeout_hit) begin
         state_d = S_IDLE;
      end else if (bus.rx_done) begin
         case (state_q)
            S_IDLE:    if (is_sync) state_d = S_CMD;
            S_CMD:     state_d = S_LEN_LO;
            S_LEN_LO:  state_d = S_LEN_HI;
            S_LEN_HI: begin
               if (len_ovf) begin
                  state_d = S_IDLE;
               end else if (len_zero) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_PAYLOAD;
               end
            end
            S_PAYLOAD: if (last_byte) state_d = S_CHECK;
            S_CHECK:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // Output and datapath next values; pulses default low, everything else holds
   always_comb begin
      cnt_d      = cnt_q;
      len_d      = len_q;
      csum_d     = csum_q;
      wr_en_d    = 1'b0;
      wr_sel_d   = wr_sel_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;

      // Inter-byte idle counter only runs inside a packet
      if (state_q == S_IDLE || bus.rx_done) begin
         idle_cnt_d = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + TO_W'(1);
      end

      if (timeout_hit) begin
         err_d      = 1'b1;
         err_code_d = ERR_TIMEOUT;
         busy_d     = 1'b0;
      end else if (bus.rx_done) begin
         case (state_q)
            S_IDLE: begin
               if (is_sync) begin
                  busy_d     = 1'b1;
                  err_code_d = ERR_NONE;
               end
            end
            S_CMD: begin
               wr_sel_d = bus.rx_data[0];
               csum_d   = bus.rx_data;
            end
            S_LEN_LO: begin
               len_d  = {8'h00, bus.rx_data};
               csum_d = csum_q ^ bus.rx_data;
            end
            S_LEN_HI: begin
               len_d  = len_full;
               csum_d = csum_q ^ bus.rx_data;
               cnt_d  = '0;
               if (len_ovf) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_LEN;
                  busy_d     = 1'b0;
               end
            end
            S_PAYLOAD: begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q[ADDR_W-1:0];
               wr_data_d = bus.rx_data;
               csum_d    = csum_q ^ bus.rx_data;
               cnt_d     = cnt_q + CNT_W'(1);
            end
            S_CHECK: begin
               busy_d = 1'b0;
               if (bus.rx_data == csum_q) begin
                  done_d = 1'b1;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_CSUM;
               end
            end
            default: begin
               busy_d = 1'b0;
            end
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         len_q      <= '0;
         csum_q     <= '0;
         idle_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         wr_sel_q   <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         csum_q     <= csum_d;
         idle_cnt_q <= idle_cnt_d;
         wr_en_q    <= wr_en_d;
         wr_sel_q   <= wr_sel_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign bus.wr_en    = wr_en_q;
   assign bus.wr_sel   = wr_sel_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = busy_q;
   assign bus.pkt_done = done_q;
   assign bus.pkt_err  = err_q;
   assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_uart_packet_loader.sv
// Self-checking bench for uart_packet_loader (ADDR_W=4, TIMEOUT_CLKS=50).
module tb_uart_packet_loader;

   localparam int unsigned TB_ADDR_W  = 4;
   localparam int unsigned TB_TIMEOUT = 50;
   localparam int          MAX_LEN    = 16;

   logic clk = 1'b0;
   logic reset_n;

   uart_packet_loader_if #(.ADDR_W(TB_ADDR_W)) bus ();

   uart_packet_loader #(
      .ADDR_W      (TB_ADDR_W),
      .TIMEOUT_CLKS(TB_TIMEOUT),
      .SYNC_BYTE   (8'hA5)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   int         n_wr     = 0;
   int         n_done   = 0;
   int         n_err    = 0;
   logic [1:0] exp_code = 2'd0;

   // Pulse counters plus cycle-by-cycle sanity on every pulse
   always @(negedge clk) begin
      if (bus.wr_en) n_wr++;
      if (bus.pkt_done) n_done++;
      if (bus.pkt_err) n_err++;
      if (bus.pkt_done || bus.pkt_err || bus.wr_en) begin
         checks++;
         if ((bus.pkt_done && bus.pkt_err) || (bus.wr_en && !bus.busy)) begin
            failures++;
            $display("FAIL pulse_sanity t=%0t: done=%b err=%b wr_en=%b busy=%b, required done&err=0 and wr_en->busy",
                     $time, bus.pkt_done, bus.pkt_err, bus.wr_en, bus.busy);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Canonical observation word; address/data/sel only meaningful on a write
   function automatic logic [31:0] pack(input logic en, input logic sel, input logic done,
                                        input logic err, input logic bsy, input logic [1:0] code,
                                        input logic [7:0] addr, input logic [7:0] data);
      return {en, en ? sel : 1'b0, done, err, bsy, code, 1'b0,
              en ? addr : 8'h00, en ? data : 8'h00, 8'h00};
   endfunction

   function automatic logic [31:0] obs_now();
      return pack(bus.wr_en, bus.wr_sel, bus.pkt_done, bus.pkt_err, bus.busy,
                  bus.err_code, 8'(bus.wr_addr), bus.wr_data);
   endfunction

   // Strobe one byte after `gap` idle cycles; return outputs of the following cycle
   task automatic send_byte(input logic [7:0] b, input int gap, output logic [31:0] obs);
      repeat (gap) @(negedge clk);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      @(negedge clk);
      bus.rx_done = 1'b0;
      bus.rx_data = 8'($urandom);
      obs = obs_now();
   endtask

   // Reference model: expected response of each byte is derived from its position in the frame
   task automatic play_frame(input string tag, input logic [7:0] garbage[$], input logic [7:0] cmd,
                             input int len, input logic [7:0] pl[$], input logic [7:0] csum_mask,
                             input int gmin, input int gmax);
      logic [7:0]  bytes[$];
      logic [31:0] exp[$];
      logic [31:0] obs;
      logic [7:0]  lo, hi, sum;
      int          w0, d0, e0, exp_w, exp_d, exp_e;
      w0 = n_wr; d0 = n_done; e0 = n_err;
      exp_w = 0; exp_d = 0; exp_e = 0;
      lo = len[7:0];
      hi = len[15:8];
      foreach (garbage[i]) begin
         bytes.push_back(garbage[i]);
         exp.push_back(pack(0, 0, 0, 0, 0, exp_code, 8'h00, 8'h00));
      end
      exp_code = 2'd0;
      bytes.push_back(8'hA5); exp.push_back(pack(0, 0, 0, 0, 1, 2'd0, 8'h00, 8'h00));
      bytes.push_back(cmd);   exp.push_back(pack(0, 0, 0, 0, 1, 2'd0, 8'h00, 8'h00));
      bytes.push_back(lo);    exp.push_back(pack(0, 0, 0, 0, 1, 2'd0, 8'h00, 8'h00));
      bytes.push_back(hi);
      if (len > MAX_LEN) begin
         exp_code = 2'd2;
         exp.push_back(pack(0, 0, 0, 1, 0, 2'd2, 8'h00, 8'h00));
         exp_e = 1;
      end else begin
         exp.push_back(pack(0, 0, 0, 0, 1, 2'd0, 8'h00, 8'h00));
         sum = cmd ^ lo ^ hi;
         for (int i = 0; i < len; i++) begin
            bytes.push_back(pl[i]);
            exp.push_back(pack(1, cmd[0], 0, 0, 1, 2'd0, 8'(i), pl[i]));
            sum ^= pl[i];
            exp_w++;
         end
         bytes.push_back(sum ^ csum_mask);
         if (csum_mask == 8'h00) begin
            exp.push_back(pack(0, 0, 1, 0, 0, 2'd0, 8'h00, 8'h00));
            exp_d = 1;
         end else begin
            exp_code = 2'd1;
            exp.push_back(pack(0, 0, 0, 1, 0, 2'd1, 8'h00, 8'h00));
            exp_e = 1;
         end
      end
      foreach (bytes[i]) begin
         send_byte(bytes[i], $urandom_range(gmax, gmin), obs);
         checks++;
         if (obs !== exp[i]) begin
            failures++;
            $display("FAIL %s byte%0d (0x%02h): got %08h required %08h", tag, i, bytes[i], obs, exp[i]);
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({n_wr - w0, n_done - d0, n_err - e0} !== {exp_w, exp_d, exp_e}) begin
         failures++;
         $display("FAIL %s pulse_counts: got wr=%0d done=%0d err=%0d required wr=%0d done=%0d err=%0d",
                  tag, n_wr - w0, n_done - d0, n_err - e0, exp_w, exp_d, exp_e);
      end
   endtask

   task automatic test_reset();
      logic [23:0] raw;
      raw = {bus.wr_en, bus.wr_sel, 8'(bus.wr_addr), bus.wr_data, bus.busy,
             bus.pkt_done, bus.pkt_err, bus.err_code};
      checks++;
      if (raw !== 24'h0) begin
         failures++;
         $display("FAIL reset_values: got %06h required 000000", raw);
      end
      reset_n = 1'b1;
      exp_code = 2'd0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good_and_bad_csum();
      logic [7:0] g[$];
      logic [7:0] pl[$];
      pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
      play_frame("good_frame", g, 8'h01, 3, pl, 8'h00, 1, 3);
      play_frame("bad_csum", g, 8'h01, 3, pl, 8'h01, 1, 3);
   endtask

   task automatic test_len_limits();
      logic [7:0] g[$];
      logic [7:0] pl[$];
      play_frame("len_overflow", g, 8'h00, 17, pl, 8'h00, 1, 2);
      play_frame("len_overflow_big", g, 8'h01, 16'hFF10, pl, 8'h00, 1, 2);
      for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom));
      play_frame("len_max", g, 8'h00, MAX_LEN, pl, 8'h00, 1, 2);
   endtask

   task automatic test_garbage_zero_len();
      logic [7:0] g[$];
      logic [7:0] pl[$];
      g.push_back(8'h00); g.push_back(8'hFF); g.push_back(8'h5A);
      play_frame("garbage_zero_len", g, 8'h00, 0, pl, 8'h00, 1, 3);
   endtask

   task automatic test_timeout();
      logic [7:0]  g[$];
      logic [7:0]  pl[$];
      logic [31:0] obs;
      int          k, e0;
      bit          found;
      send_byte(8'hA5, 2, obs);
      send_byte(8'h00, 1, obs);
      send_byte(8'h02, 1, obs);
      send_byte(8'h00, 1, obs);
      send_byte(8'h11, 1, obs);
      checks++;
      if (obs !== pack(1, 0, 0, 0, 1, 2'd0, 8'h00, 8'h11)) begin
         failures++;
         $display("FAIL timeout_first_write: got %08h required %08h", obs, pack(1, 0, 0, 0, 1, 2'd0, 8'h00, 8'h11));
      end
      e0 = n_err;
      k = 0;
      found = 1'b0;
      while (!found && k < 100) begin
         @(negedge clk);
         k++;
         if (bus.pkt_err) found = 1'b1;
      end
      checks++;
      if (!found || k != TB_TIMEOUT) begin
         failures++;
         $display("FAIL timeout_latency: got found=%0d after %0d clocks, required pkt_err after %0d clocks", found, k, TB_TIMEOUT);
      end
      checks++;
      if ({bus.err_code, bus.busy, bus.pkt_done} !== {2'd3, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL timeout_code: got code=%0d busy=%b done=%b required code=3 busy=0 done=0",
                  bus.err_code, bus.busy, bus.pkt_done);
      end
      exp_code = 2'd3;
      repeat (150) @(negedge clk);
      checks++;
      if ((n_err - e0) !== 1 || bus.err_code !== 2'd3) begin
         failures++;
         $display("FAIL idle_no_timeout: got %0d err pulses code=%0d, required 1 pulse code=3", n_err - e0, bus.err_code);
      end
      pl.push_back(8'h5C); pl.push_back(8'hC3);
      play_frame("after_timeout", g, 8'h01, 2, pl, 8'h00, 1, 3);
      // Every byte lands exactly on the expiry cycle: the byte must win
      pl.delete();
      pl.push_back(8'h77);
      play_frame("timeout_edge", g, 8'h00, 1, pl, 8'h00, TB_TIMEOUT - 1, TB_TIMEOUT - 1);
   endtask

   task automatic test_reset_mid_payload();
      logic [7:0]  g[$];
      logic [7:0]  pl[$];
      logic [31:0] obs;
      logic [23:0] raw;
      send_byte(8'hA5, 2, obs);
      send_byte(8'h00, 1, obs);
      send_byte(8'h04, 1, obs);
      send_byte(8'h00, 1, obs);
      send_byte(8'h11, 1, obs);
      send_byte(8'h22, 1, obs);
      checks++;
      if (obs !== pack(1, 0, 0, 0, 1, 2'd0, 8'h01, 8'h22)) begin
         failures++;
         $display("FAIL reset_mid_pre: got %08h required %08h", obs, pack(1, 0, 0, 0, 1, 2'd0, 8'h01, 8'h22));
      end
      reset_n = 1'b0;
      #1;
      raw = {bus.wr_en, bus.wr_sel, 8'(bus.wr_addr), bus.wr_data, bus.busy,
             bus.pkt_done, bus.pkt_err, bus.err_code};
      checks++;
      if (raw !== 24'h0) begin
         failures++;
         $display("FAIL reset_mid_immediate: got %06h required 000000", raw);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      exp_code = 2'd0;
      g.push_back(8'h33); g.push_back(8'h44); g.push_back(8'h40);
      pl.push_back(8'h9E); pl.push_back(8'h01); pl.push_back(8'hA5);
      play_frame("after_reset", g, 8'h01, 3, pl, 8'h00, 1, 3);
   endtask

   task automatic test_random_frames(input int n, input int gmax, input string tag);
      logic [7:0] g[$];
      logic [7:0] pl[$];
      logic [7:0] b, mask;
      int         len;
      for (int f = 0; f < n; f++) begin
         g.delete();
         pl.delete();
         for (int i = 0; i < $urandom_range(3, 0); i++) begin
            do b = 8'($urandom); while (b == 8'hA5);
            g.push_back(b);
         end
         len = ($urandom_range(9, 0) < 2) ? $urandom_range(65535, MAX_LEN + 1) : $urandom_range(MAX_LEN, 0);
         for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom));
         mask = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         play_frame($sformatf("%s%0d", tag, f), g, 8'($urandom), len, pl, mask, 1, gmax);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      repeat (3) @(negedge clk);
      test_reset();
      test_good_and_bad_csum();
      test_len_limits();
      test_garbage_zero_len();
      test_timeout();
      test_reset_mid_payload();
      test_random_frames(20, 6, "rand");
      test_random_frames(10, 1, "b2b");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
